// File: rtl/mesm6_mem_arbiter.sv
// Merges the MESM-6 instruction and data buses onto one single-ported word memory.
// Optional one-word instruction fetch buffer: define MESM6_ARB_IFETCH_BUF_EN.
module mesm6_mem_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 48,
  parameter int DBUS_FIRST = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ibus_fetch,
  input  logic [ADDR_W-1:0] ibus_addr,
  output logic [DATA_W-1:0] ibus_input,
  output logic              ibus_done,
  input  logic              dbus_read,
  input  logic              dbus_write,
  input  logic [ADDR_W-1:0] dbus_addr,
  input  logic [DATA_W-1:0] dbus_output,
  output logic [DATA_W-1:0] dbus_input,
  output logic              dbus_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_D_ACC = 2'd1;
  localparam logic [1:0] S_I_ACC = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic              r_has_d, r_has_i;
  logic              r_pend_d, r_pend_i;
  logic              r_d_we;
  logic [ADDR_W-1:0] r_d_addr, r_i_addr;
  logic [DATA_W-1:0] r_d_wdata;

  logic w_req_d;
  logic w_hit;
  logic w_pend_i;

`ifdef MESM6_ARB_IFETCH_BUF_EN
  logic              r_buf_valid;
  logic [ADDR_W-1:0] r_buf_addr;
  logic [DATA_W-1:0] r_buf_data;
  logic              w_inval;

  // A write to the buffered word in the same set forces the fetch to memory.
  assign w_inval = dbus_write && (dbus_addr == r_buf_addr);
  assign w_hit   = r_buf_valid && ibus_fetch && (ibus_addr == r_buf_addr) && !w_inval;
`else
  assign w_hit   = 1'b0;
`endif

  assign w_req_d  = dbus_read | dbus_write;
  assign w_pend_i = ibus_fetch & ~w_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_has_d    <= 1'b0;
      r_has_i    <= 1'b0;
      r_pend_d   <= 1'b0;
      r_pend_i   <= 1'b0;
      r_d_we     <= 1'b0;
      r_d_addr   <= '0;
      r_i_addr   <= '0;
      r_d_wdata  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      ibus_done  <= 1'b0;
      dbus_done  <= 1'b0;
      ibus_input <= '0;
      dbus_input <= '0;
`ifdef MESM6_ARB_IFETCH_BUF_EN
      r_buf_valid <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_data  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_has_d   <= w_req_d;
          r_has_i   <= ibus_fetch;
          r_pend_d  <= w_req_d;
          r_pend_i  <= w_pend_i;
          r_d_we    <= dbus_write;
          r_d_addr  <= dbus_addr;
          r_d_wdata <= dbus_output;
          r_i_addr  <= ibus_addr;
`ifdef MESM6_ARB_IFETCH_BUF_EN
          if (w_inval) r_buf_valid <= 1'b0;
          if (w_hit)   ibus_input  <= r_buf_data;
`endif
          if (w_req_d && (DBUS_FIRST != 0 || !w_pend_i)) begin
            r_state   <= S_D_ACC;
            mem_req   <= 1'b1;
            mem_we    <= dbus_write;
            mem_addr  <= dbus_addr;
            mem_wdata <= dbus_output;
          end else if (w_pend_i) begin
            r_state  <= S_I_ACC;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= ibus_addr;
          end else if (ibus_fetch) begin
            r_state   <= S_DONE;
            ibus_done <= 1'b1;
          end
        end

        S_D_ACC: begin
          if (mem_ready) begin
            r_pend_d <= 1'b0;
            if (!r_d_we) dbus_input <= mem_rdata;
            if (r_pend_i) begin
              r_state  <= S_I_ACC;
              mem_we   <= 1'b0;
              mem_addr <= r_i_addr;
            end else begin
              r_state   <= S_DONE;
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
              ibus_done <= r_has_i;
              dbus_done <= r_has_d;
            end
          end
        end

        S_I_ACC: begin
          if (mem_ready) begin
            r_pend_i   <= 1'b0;
            ibus_input <= mem_rdata;
`ifdef MESM6_ARB_IFETCH_BUF_EN
            // A write to this word still queued behind the fetch would leave the buffer stale.
            r_buf_valid <= !(r_pend_d && r_d_we && (r_d_addr == r_i_addr));
            r_buf_addr  <= r_i_addr;
            r_buf_data  <= mem_rdata;
`endif
            if (r_pend_d) begin
              r_state   <= S_D_ACC;
              mem_we    <= r_d_we;
              mem_addr  <= r_d_addr;
              mem_wdata <= r_d_wdata;
            end else begin
              r_state   <= S_DONE;
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
              ibus_done <= r_has_i;
              dbus_done <= r_has_d;
            end
          end
        end

        default: begin
          ibus_done <= 1'b0;
          dbus_done <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mesm6_mem_arbiter.sv
// Directed bench for mesm6_mem_arbiter with a wait-state memory model and done-data scoreboards.
module tb_mesm6_mem_arbiter;
  localparam int AW = 15;
  localparam int DW = 48;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ibus_fetch = 1'b0;
  logic [AW-1:0] ibus_addr = '0;
  logic [DW-1:0] ibus_input;
  logic          ibus_done;
  logic          dbus_read = 1'b0;
  logic          dbus_write = 1'b0;
  logic [AW-1:0] dbus_addr = '0;
  logic [DW-1:0] dbus_output = '0;
  logic [DW-1:0] dbus_input;
  logic          dbus_done;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int wait_cycles = 0;
  int waitcnt = 0;
  int access_count = 0;
  logic [DW-1:0] iq[$];
  logic [DW-1:0] dq[$];
  logic [DW-1:0] mem [0:32767];
  logic [DW-1:0] exp_d = '0;
  logic prev_i = 1'b0;
  logic prev_d = 1'b0;

  mesm6_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DBUS_FIRST(1)) dut (
    .clk(clk), .reset(reset),
    .ibus_fetch(ibus_fetch), .ibus_addr(ibus_addr), .ibus_input(ibus_input), .ibus_done(ibus_done),
    .dbus_read(dbus_read), .dbus_write(dbus_write), .dbus_addr(dbus_addr),
    .dbus_output(dbus_output), .dbus_input(dbus_input), .dbus_done(dbus_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Memory responder: mem_ready after wait_cycles idle cycles of a held request.
  always @(negedge clk) begin
    if (mem_req) begin
      if (waitcnt < wait_cycles) begin
        mem_ready = 1'b0;
        waitcnt++;
      end else begin
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr];
        waitcnt = 0;
      end
    end else begin
      mem_ready = 1'b0;
      waitcnt = 0;
    end
  end

  always @(posedge clk) begin
    if (reset && mem_req && mem_ready) begin
      access_count++;
      if (mem_we) mem[mem_addr] = mem_wdata;
    end
  end

  // Scoreboard: each done pulse pops one expected data word.
  always @(negedge clk) begin
    if (reset) begin
      if (ibus_done) begin
        chk("ibus_done_expected", 64'(iq.size() > 0), 64'd1);
        if (iq.size() > 0) chk("ibus_input", 64'(ibus_input), 64'(iq.pop_front()));
        chk("ibus_done_adjacent", 64'(prev_i), 64'd0);
      end
      if (dbus_done) begin
        chk("dbus_done_expected", 64'(dq.size() > 0), 64'd1);
        if (dq.size() > 0) chk("dbus_input", 64'(dbus_input), 64'(dq.pop_front()));
        chk("dbus_done_adjacent", 64'(prev_d), 64'd0);
      end
    end
    prev_i = ibus_done;
    prev_d = dbus_done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    int pulses;
    for (int a = 0; a < 32768; a++) mem[a] = '0;
    mem[15'o100] = 48'h123456789ABC;
    mem[15'o300] = 48'hA5A5_0000_1111;
    mem[15'o400] = 48'h0BAD_CAFE_0042;
    mem[15'o500] = 48'h7777_8888_9999;

    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_ibus_done", 64'(ibus_done), 64'd0);
    chk("rst_dbus_done", 64'(dbus_done), 64'd0);
    chk("rst_ibus_input", 64'(ibus_input), 64'd0);
    chk("rst_dbus_input", 64'(dbus_input), 64'd0);
    reset = 1'b1;

    // single zero-wait fetch
    ibus_fetch = 1'b1; ibus_addr = 15'o100;
    iq.push_back(48'h123456789ABC);
    tick;
    chk("f1_t1_mem_req", 64'(mem_req), 64'd1);
    chk("f1_t1_mem_addr", 64'(mem_addr), 64'(15'o100));
    chk("f1_t1_mem_we", 64'(mem_we), 64'd0);
    chk("f1_t1_ibus_done", 64'(ibus_done), 64'd0);
    tick;
    chk("f1_t2_ibus_done", 64'(ibus_done), 64'd1);
    chk("f1_t2_mem_req", 64'(mem_req), 64'd0);
    ibus_fetch = 1'b0;
    tick;
    chk("f1_t3_ibus_done", 64'(ibus_done), 64'd0);

    // write with three wait states
    wait_cycles = 3;
    dbus_write = 1'b1; dbus_addr = 15'o2000; dbus_output = 48'hFFFF00000001;
    dq.push_back(exp_d);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("wr_mem_req", 64'(mem_req), 64'd1);
      chk("wr_mem_we", 64'(mem_we), 64'd1);
      chk("wr_mem_addr", 64'(mem_addr), 64'(15'o2000));
      chk("wr_mem_wdata", 64'(mem_wdata), 64'h0000FFFF00000001);
      chk("wr_dbus_done_early", 64'(dbus_done), 64'd0);
    end
    tick;
    chk("wr_dbus_done", 64'(dbus_done), 64'd1);
    chk("wr_mem_req_drop", 64'(mem_req), 64'd0);
    dbus_write = 1'b0;
    tick;
    chk("wr_dbus_done_end", 64'(dbus_done), 64'd0);
    chk("wr_mem_content", 64'(mem[15'o2000]), 64'h0000FFFF00000001);

    // read + fetch in one set, data first
    wait_cycles = 0;
    ibus_fetch = 1'b1; ibus_addr = 15'o400;
    dbus_read = 1'b1; dbus_addr = 15'o300;
    iq.push_back(48'h0BAD_CAFE_0042);
    dq.push_back(48'hA5A5_0000_1111);
    exp_d = 48'hA5A5_0000_1111;
    tick;
    chk("dual_t1_mem_req", 64'(mem_req), 64'd1);
    chk("dual_t1_mem_addr", 64'(mem_addr), 64'(15'o300));
    chk("dual_t1_dones", 64'({ibus_done, dbus_done}), 64'd0);
    tick;
    chk("dual_t2_mem_req", 64'(mem_req), 64'd1);
    chk("dual_t2_mem_addr", 64'(mem_addr), 64'(15'o400));
    chk("dual_t2_dones", 64'({ibus_done, dbus_done}), 64'd0);
    tick;
    chk("dual_t3_dones", 64'({ibus_done, dbus_done}), 64'd3);
    chk("dual_t3_mem_req", 64'(mem_req), 64'd0);
    ibus_fetch = 1'b0; dbus_read = 1'b0;
    tick;
    chk("dual_t4_dones", 64'({ibus_done, dbus_done}), 64'd0);

    // reset asserted during a memory wait
    wait_cycles = 5;
    dbus_read = 1'b1; dbus_addr = 15'o300;
    tick;
    chk("rstmid_t1_mem_req", 64'(mem_req), 64'd1);
    tick;
    chk("rstmid_t2_mem_req", 64'(mem_req), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("rstmid_mem_req", 64'(mem_req), 64'd0);
    chk("rstmid_mem_addr", 64'(mem_addr), 64'd0);
    chk("rstmid_dones", 64'({ibus_done, dbus_done}), 64'd0);
    chk("rstmid_ibus_input", 64'(ibus_input), 64'd0);
    chk("rstmid_dbus_input", 64'(dbus_input), 64'd0);
    exp_d = '0;
    dbus_read = 1'b0;
    tick;
    tick;
    reset = 1'b1;
    wait_cycles = 0;
    ibus_fetch = 1'b1; ibus_addr = 15'o100;
    iq.push_back(48'h123456789ABC);
    tick;
    chk("rstmid_f_mem_req", 64'(mem_req), 64'd1);
    chk("rstmid_f_mem_addr", 64'(mem_addr), 64'(15'o100));
    tick;
    chk("rstmid_f_ibus_done", 64'(ibus_done), 64'd1);
    ibus_fetch = 1'b0;
    tick;

    // same read held across three back-to-back sets
    acc0 = access_count;
    pulses = 0;
    dbus_read = 1'b1; dbus_addr = 15'o500;
    for (int k = 0; k < 3; k++) dq.push_back(48'h7777_8888_9999);
    exp_d = 48'h7777_8888_9999;
    for (int k = 0; k < 30 && pulses < 3; k++) begin
      tick;
      if (dbus_done) pulses++;
    end
    dbus_read = 1'b0;
    chk("b2b_pulses", 64'(pulses), 64'd3);
    repeat (3) tick;
    chk("b2b_accesses", 64'(access_count - acc0), 64'd3);
    chk("b2b_dbus_done_idle", 64'(dbus_done), 64'd0);

    // repeated fetch of the last fetched word
    acc0 = access_count;
    ibus_fetch = 1'b1; ibus_addr = 15'o100;
    iq.push_back(48'h123456789ABC);
`ifdef MESM6_ARB_IFETCH_BUF_EN
    tick;
    chk("buf_hit_ibus_done", 64'(ibus_done), 64'd1);
    chk("buf_hit_mem_req", 64'(mem_req), 64'd0);
    ibus_fetch = 1'b0;
    tick;
    chk("buf_hit_accesses", 64'(access_count - acc0), 64'd0);
    chk("buf_hit_done_end", 64'(ibus_done), 64'd0);
`else
    tick;
    chk("refetch_mem_req", 64'(mem_req), 64'd1);
    tick;
    chk("refetch_ibus_done", 64'(ibus_done), 64'd1);
    ibus_fetch = 1'b0;
    tick;
    chk("refetch_accesses", 64'(access_count - acc0), 64'd1);
`endif

    // write to that word, then fetch it again: must go to memory
    dbus_write = 1'b1; dbus_addr = 15'o100; dbus_output = 48'h0000AAAA5555;
    dq.push_back(exp_d);
    tick;
    chk("inv_wr_mem_req", 64'(mem_req), 64'd1);
    chk("inv_wr_mem_we", 64'(mem_we), 64'd1);
    tick;
    chk("inv_wr_dbus_done", 64'(dbus_done), 64'd1);
    dbus_write = 1'b0;
    tick;
    chk("inv_wr_mem_content", 64'(mem[15'o100]), 64'h0000_0000AAAA5555);
    ibus_fetch = 1'b1; ibus_addr = 15'o100;
    iq.push_back(48'h0000AAAA5555);
    tick;
    chk("inv_f_mem_req", 64'(mem_req), 64'd1);
    chk("inv_f_mem_addr", 64'(mem_addr), 64'(15'o100));
    chk("inv_f_mem_we", 64'(mem_we), 64'd0);
    tick;
    chk("inv_f_ibus_done", 64'(ibus_done), 64'd1);
    ibus_fetch = 1'b0;
    repeat (2) tick;

    chk("iq_drained", 64'(iq.size()), 64'd0);
    chk("dq_drained", 64'(dq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mesm6_mem_arbiter.md
Name: mesm6_mem_arbiter

Overview:
- Memory-side neighbour of the MESM-6 core. It merges the core's instruction bus (ibus) and data bus (dbus) onto one single-ported 48-bit word memory port.
- A request set is latched once. Its accesses are serialized, and the core sees all done strobes in the same cycle, so its stall logic never re-issues an already-served access.
- Sits between mesm6_core and the SRAM/BRAM controller.

Parameters:
- ADDR_W, 15: word address width.
- DATA_W, 48: word width.
- DBUS_FIRST, 1: 1 = data access before instruction fetch within one set; 0 = fetch first.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- ibus_fetch  input  1  instruction fetch request, held by core until ibus_done
- ibus_addr  input  ADDR_W  fetch word address
- ibus_input  output  DATA_W  fetched instruction word, registered
- ibus_done  output  1  fetch complete, one-cycle pulse
- dbus_read  input  1  data read request
- dbus_write  input  1  data write request
- dbus_addr  input  ADDR_W  data word address
- dbus_output  input  DATA_W  write data from core accumulator
- dbus_input  output  DATA_W  read data, registered
- dbus_done  output  1  data op complete, one-cycle pulse
- mem_req  output  1  memory access request, held until mem_ready
- mem_we  output  1  1 = write
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data, valid when mem_ready=1
- mem_ready  input  1  memory completes current access this cycle

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - ibus_done=0, dbus_done=0; ibus_input=0, dbus_input=0; pending flags=0.
  - Reset mid-access drops mem_req immediately and the set is discarded.
- All outputs are registered.
- States: IDLE, D_ACC, I_ACC, DONE.
- IDLE:
  - Sample the request set: pend_d = dbus_read|dbus_write, pend_i = ibus_fetch.
  - Latch addresses, write data and the we flag. dbus_read&dbus_write together is treated as a write.
  - If no request, stay in IDLE. Otherwise go to the first pending access per DBUS_FIRST.
- D_ACC / I_ACC:
  - mem_req=1 with address/data from the latched values; everything is held stable while mem_ready=0 (unbounded wait).
  - On mem_ready: capture mem_rdata into dbus_input (reads only) or ibus_input, and clear that pending flag.
  - Then go to the other access if still pending, else DONE.
  - mem_req is 0 for the cycle after mem_ready, or stays 1 when going straight to the next access of the set.
- DONE:
  - Assert ibus_done and/or dbus_done for exactly one cycle, for every member of the set. Unrequested done stays 0.
  - Go to IDLE.
  - Request inputs during DONE are ignored. Requests seen in the following IDLE are a new set.
- Latency with zero-wait memory (mem_ready=1 whenever mem_req=1), request visible at cycle t:
  - single access: mem_req at t+1, done at t+2.
  - dual access: mem_req at t+1 and t+2, done at t+3.
- Data outputs hold their value until overwritten by a later capture. dbus_input is not changed by writes.
- Request inputs changing while a set is in flight are ignored. The latched values are used.

Optional Feature:
- Macro MESM6_ARB_IFETCH_BUF_EN.
- Defined: adds a one-word fetch buffer (valid bit, address, data), set on each completed I_ACC.
  - A fetch whose address matches the valid buffer is served from it with no mem_req.
  - Served alone, it goes IDLE->DONE, so done arrives at t+1.
  - Served with a data access, the fetch is skipped in the sequence.
  - Any write whose latched dbus_addr matches the buffer address clears valid when the write is accepted in IDLE.
  - Reset clears valid.
- Undefined: every fetch performs a memory access; no buffer storage exists.

Test Plan:
- Reset released, ibus_fetch=1, ibus_addr=0o100, memory word 0x123456789ABC, zero-wait -> mem_req=1/mem_addr=0o100 at t+1; ibus_done=1 and ibus_input=0x123456789ABC at t+2, single pulse.
- dbus_write=1, dbus_addr=0o2000, dbus_output=0xFFFF00000001, mem_ready delayed 3 cycles -> mem_we=1 and mem_wdata held stable 4 cycles; dbus_done one cycle after mem_ready; dbus_input unchanged.
- ibus_fetch and dbus_read together, DBUS_FIRST=1, zero-wait -> data access at t+1, fetch at t+2, ibus_done and dbus_done both 1 at t+3 only.
- reset driven low while mem_req=1 mid-wait -> mem_req, done and data outputs 0 immediately; after release, a new fetch completes normally.
- Same request held for 3 consecutive sets (core issuing back-to-back reads) -> exactly 3 memory accesses and 3 dbus_done pulses, never 2 pulses in adjacent cycles.
- With MESM6_ARB_IFETCH_BUF_EN:
  - second fetch of 0o100 -> ibus_done at t+1, no mem_req;
  - after a dbus_write to 0o100, the next fetch of 0o100 issues mem_req.
